reg_serial_reader: RTL and testbench
====================================

REG_SERIAL_READER -- requirements
Module: reg_serial_reader

Interface
REQ-001 The block SHALL have the port `clock`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have the port `start`: input, 1 bit, request to capture `data` and serialize it.
REQ-004 The block SHALL have the port `abort`: input, 1 bit, cancels an in-progress transfer.
REQ-005 The block SHALL have the port `data`: input, 32 bits, parallel word read from a 32-bit register output.
REQ-006 The block SHALL have the port `bit_out`: output, 1 bit, current serial bit, LSB first.
REQ-007 The block SHALL have the port `bit_valid`: output, 1 bit, high while `bit_out` carries a payload or parity bit.
REQ-008 The block SHALL have the port `busy`: output, 1 bit, high in SHIFT or PARITY.
REQ-009 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse after the last bit.
REQ-010 The block SHALL have the port `count`: output, 6 bits, number of payload bits already emitted in the current transfer.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, PARITY and DONE, and all outputs SHALL be registered.
REQ-012 In IDLE or DONE, with start=1 and abort=0 at an edge, the block SHALL load `data` into a 32-bit shadow register, set count=0 and enter SHIFT.
REQ-013 In SHIFT, the block SHALL drive bit_out=shadow[count] and bit_valid=1, and SHALL increment count at each edge.
REQ-014 At the edge where count==31 in SHIFT, the block SHALL go to PARITY when READ_PARITY_EN is defined, otherwise to DONE, and count SHALL saturate at 32.
REQ-015 In PARITY, the block SHALL drive bit_out as the XOR of all 32 shadow bits (even parity) with bit_valid=1, and SHALL go to DONE at the next edge.
REQ-016 In DONE, the block SHALL assert done=1 with bit_valid=0 and busy=0 for exactly one cycle, then go to IDLE unless start is accepted per REQ-012.
REQ-017 Latency: with start sampled at edge k, bit i SHALL be valid in the cycle after edge k+i for i=0..31, and done SHALL be high in the cycle after edge k+32 (k+33 with parity).
REQ-018 The block SHALL ignore start while busy=1, and SHALL NOT modify the shadow register during a transfer even when `data` changes.
REQ-019 With abort=1 at an edge in SHIFT or PARITY, the block SHALL go to IDLE with no done pulse, bit_valid=0 and count=0.
REQ-020 When start=1 and abort=1 arrive together in IDLE or DONE, abort SHALL win: the block stays in or enters IDLE and no capture occurs.
REQ-021 In IDLE, the block SHALL drive bit_out=0, bit_valid=0, busy=0 and done=0.

Reset
REQ-022 With reset=1, the block SHALL immediately (asynchronously) force IDLE, shadow=0, count=0, bit_out=0, bit_valid=0, busy=0 and done=0.
REQ-023 When reset is asserted mid-transfer, the block SHALL discard the transfer with no done pulse, and the first edge after release SHALL behave as IDLE.

Configuration
REQ-024 The macro READ_PARITY_EN SHALL control the parity bit: when defined, one parity bit follows the 32 payload bits (transfer takes 33 valid cycles).
REQ-025 When READ_PARITY_EN is undefined, the block SHALL have no PARITY state and no parity logic, and the transfer SHALL take 32 valid cycles.

Verification
REQ-026 The bench SHALL check: data=32'hA5A5_0F0F, start pulse, no parity -> bit_out sequence 1,1,1,1,0,0,0,0,... LSB first over 32 valid cycles, done high in cycle 33, count=32 at done.
REQ-027 The bench SHALL check, with READ_PARITY_EN: data=32'h0000_0007 -> 32 payload bits, then parity bit=1, and done in cycle 34.
REQ-028 The bench SHALL check: data changed to 32'hFFFF_FFFF in cycle 5 of a transfer of 32'h0 -> all 32 bits emitted are 0.
REQ-029 The bench SHALL check: abort at count=10 -> bit_valid=0 next cycle, count=0, no done pulse, and a following start is accepted normally.
REQ-030 The bench SHALL check: start held high continuously -> transfers run back-to-back, the DONE cycle immediately re-captures `data`, and no IDLE gap occurs.
REQ-031 The bench SHALL check: reset asserted asynchronously between edges at count=20 -> all outputs 0 before the next edge, and start after release begins a fresh transfer.

Source files
------------

// File: rtl/reg_serial_reader_if.sv
// Handshake and serial-output bundle for reg_serial_reader.
// The master side requests transfers; the slave side produces the serial stream.
interface reg_serial_reader_if;
    logic        start;
    logic        abort;
    logic [31:0] data;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic [5:0]  count;

    modport master (
        output start, abort, data,
        input  bit_out, bit_valid, busy, done, count
    );

    modport slave (
        input  start, abort, data,
        output bit_out, bit_valid, busy, done, count
    );
endinterface

// File: rtl/reg_serial_reader.sv
// Captures a 32-bit register word and shifts it out LSB first with registered outputs.
// Define READ_PARITY_EN to append one even-parity bit after the payload.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// SHIFT  | emitting payload bit shadow[count]
// PARITY | emitting XOR of all shadow bits (READ_PARITY_EN only)
// DONE   | one-cycle done pulse; may re-capture on start
module reg_serial_reader (
    input  logic               clock,
    input  logic               reset,
    reg_serial_reader_if.slave bus
);

`ifdef READ_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] shadow;
    logic [31:0] shadow_next;
    logic [5:0]  count;
    logic [5:0]  count_next;
    logic        accept;

    logic        bit_out_q;
    logic        bit_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        bit_out_next;
    logic        bit_valid_next;
    logic        busy_next;
    logic        done_next;

    // Abort dominates start, so a simultaneous start/abort never captures.
    assign accept = bus.start && !bus.abort && (state == IDLE || state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= 32'd0;
            count       <= 6'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            shadow      <= shadow_next;
            count       <= count_next;
            bit_out_q   <= bit_out_next;
            bit_valid_q <= bit_valid_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (bus.abort)
                    state_next = IDLE;
                else if (count == 6'd31)
`ifdef READ_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = DONE;
`endif
            end
`ifdef READ_PARITY_EN
            PARITY: begin
                if (bus.abort)
                    state_next = IDLE;
                else
                    state_next = DONE;
            end
`endif
            DONE: begin
                if (accept)
                    state_next = SHIFT;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Count saturates at 32 through PARITY/DONE and clears whenever we fall back to IDLE.
    always_comb begin
        shadow_next = shadow;
        count_next  = count;
        if (accept) begin
            shadow_next = bus.data;
            count_next  = 6'd0;
        end else if (state_next == IDLE) begin
            count_next = 6'd0;
        end else if (state == SHIFT) begin
            count_next = count + 6'd1;
        end
    end

    // Outputs are computed from next-state values so the registers line up with the state.
    always_comb begin
        bit_out_next   = 1'b0;
        bit_valid_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        case (state_next)
            SHIFT: begin
                bit_out_next   = shadow_next[count_next[4:0]];
                bit_valid_next = 1'b1;
                busy_next      = 1'b1;
            end
`ifdef READ_PARITY_EN
            PARITY: begin
                bit_out_next   = ^shadow_next;
                bit_valid_next = 1'b1;
                busy_next      = 1'b1;
            end
`endif
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                bit_out_next = 1'b0;
            end
        endcase
    end

    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count;

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed self-checking bench for reg_serial_reader; covers both READ_PARITY_EN builds.
module tb_reg_serial_reader;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    reg_serial_reader_if bus ();

    reg_serial_reader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " bit_out"},   64'(bus.bit_out),   64'd0);
        chk({tag, " bit_valid"}, 64'(bus.bit_valid), 64'd0);
        chk({tag, " busy"},      64'(bus.busy),      64'd0);
        chk({tag, " done"},      64'(bus.done),      64'd0);
        chk({tag, " count"},     64'(bus.count),     64'd0);
    endtask

    // Starts a transfer of word; optionally changes data mid-transfer and keeps start high.
    task automatic run_xfer(input string tag, input logic [31:0] word, input int chg_at,
                            input logic [31:0] chg_data, input bit hold);
        bus.data  = word;
        bus.start = 1'b1;
        tick();
        bus.start = hold;
        for (int i = 0; i < 32; i++) begin
            if (i == chg_at)
                bus.data = chg_data;
            chk($sformatf("%s bit%0d", tag, i),   64'(bus.bit_out),   64'(word[i]));
            chk($sformatf("%s valid%0d", tag, i), 64'(bus.bit_valid), 64'd1);
            chk($sformatf("%s count%0d", tag, i), 64'(bus.count),     64'(i));
            tick();
        end
`ifdef READ_PARITY_EN
        chk({tag, " parity"},       64'(bus.bit_out),   64'(^word));
        chk({tag, " parity valid"}, 64'(bus.bit_valid), 64'd1);
        chk({tag, " parity count"}, 64'(bus.count),     64'd32);
        tick();
`endif
        chk({tag, " done"},       64'(bus.done),      64'd1);
        chk({tag, " done valid"}, 64'(bus.bit_valid), 64'd0);
        chk({tag, " done busy"},  64'(bus.busy),      64'd0);
        chk({tag, " done count"}, 64'(bus.count),     64'd32);
        if (!hold) begin
            tick();
            chk_quiet({tag, " after"});
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.data  = 32'h0;
        repeat (3) tick();
        chk_quiet("reset");
        reset = 1'b0;
        tick();
        chk_quiet("idle");

        // Payload A5A5_0F0F emits 1,1,1,1,0,0,0,0,... LSB first.
        run_xfer("a5a5", 32'hA5A5_0F0F, -1, 32'h0, 1'b0);
        // 0000_0007 has odd weight, so the even-parity bit is 1.
        run_xfer("seven", 32'h0000_0007, -1, 32'h0, 1'b0);
        // Data changes mid-transfer must not reach the shadow.
        run_xfer("shadow", 32'h0000_0000, 5, 32'hFFFF_FFFF, 1'b0);

        // Abort at count 10.
        bus.data  = 32'h1234_5678;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("abort pre count", 64'(bus.count), 64'd10);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_quiet("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort no done %0d", i), 64'(bus.done), 64'd0);
        end
        run_xfer("post abort", 32'hDEAD_BEEF, -1, 32'h0, 1'b0);

        // Start and abort together in IDLE: no capture.
        bus.data  = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_quiet("start+abort");

        // Start held high: the DONE cycle re-captures with no IDLE gap.
        run_xfer("b2b first", 32'h8000_0001, -1, 32'h0, 1'b1);
        run_xfer("b2b second", 32'h3C3C_C3C3, -1, 32'h0, 1'b0);

        // Asynchronous reset between edges at count 20.
        bus.data  = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        chk("rst pre count", 64'(bus.count), 64'd20);
        chk("rst pre valid", 64'(bus.bit_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_quiet("async rst");
        #2;
        reset = 1'b0;
        tick();
        chk_quiet("rst release");
        run_xfer("post rst", 32'h0F0F_A5A5, -1, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
